fizzbuzz_tx_sequencer: RTL and testbench
========================================

# fizzbuzz_tx_sequencer

Controller that sequences the UART transmit path to print the FizzBuzz sequence from 1 to N_MAX, one line per value terminated by CR LF. It sits between the top-level control inputs and the byte-stream transmit interface of the UART block. It drives that interface with a valid/ready handshake. It uses no dividers: classification comes from mod-3/mod-5 counters, and decimal text comes from a BCD counter.

## Interface
- N_MAX, default 100: last value printed; 1 ≤ N_MAX < 10^DIGITS.
- DIGITS, default 4: number of BCD digits in the value counter.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- abort  in  1  level; ends the run at the next byte boundary.
- tx_data  out  8  ASCII byte offered to the UART transmitter.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse after the final LF is accepted.
- count  out  4*DIGITS  BCD value of the current line.

## Operation
- Reset values: tx_valid=0, tx_data=0x00, busy=0, done=0, count=0, state IDLE.
- States and transitions:
  - IDLE → CLASSIFY on start, if abort is low. At the same time: count=1, mod3=1, mod5=1, busy=1.
  - CLASSIFY selects the line content:
    - mod3==0 and mod5==0 → word "FizzBuzz".
    - mod3==0 only → "Fizz".
    - mod5==0 only → "Buzz".
    - otherwise → decimal text of count.
  - EMIT_WORD / EMIT_DIGITS → EMIT_CR → EMIT_LF.
  - After LF is accepted: if count==N_MAX go to DONE, else go to NEXT.
  - NEXT increments count, mod3 (wraps 2→0) and mod5 (wraps 4→0), then → CLASSIFY.
  - DONE: done=1 and busy=0 for one cycle, then → IDLE.
- Decimal text: most-significant digit first; leading zeros suppressed; byte = 0x30 + digit. count is never 0 during a run.
- ASCII bytes: F=0x46, i=0x69, z=0x7A, B=0x42, u=0x75, CR=0x0D, LF=0x0A.
- Handshake:
  - A byte transfers on a rising edge where tx_valid and tx_ready are both 1.
  - While tx_valid=1 and tx_ready=0, tx_data is stable and tx_valid is not withdrawn.
- abort:
  - If no byte is pending, the block goes to IDLE on the next edge.
  - If a byte is pending, it is held until accepted, then the block goes to IDLE.
  - No done pulse is produced; count holds its value.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, block stays IDLE.
- count holds the last value after DONE until the next start.
- Reset mid-run: all outputs return to their reset values immediately (asynchronous). Any partial line is discarded.

## Timing
- start sampled at edge k → CLASSIFY in cycle k+1 → first tx_valid=1 in cycle k+2.
- Within a line, with tx_ready=1, bytes go back-to-back: one byte per cycle.
- Between lines: LF accepted at edge j → NEXT, then CLASSIFY → next first byte valid in cycle j+3 (two bubble cycles).
- Final LF accepted at edge j → done=1 and busy=0 in cycle j+1 → IDLE in cycle j+2.
- busy rises in the cycle after start is sampled.

## Structure
- Shared package fizzbuzz_pkg holds:
  - the state enum;
  - the ASCII constants;
  - the word ROM content: "Fizz" and "Buzz" with index ranges. "FizzBuzz" is "Fizz" followed by "Buzz".
- Sub-module bcd_counter: DIGITS-digit incrementer with synchronous load-to-1 and ripple carry. It exposes per-digit outputs and a first-nonzero-digit index for leading-zero suppression.
- The main FSM, the mod counters and the byte mux stay in fizzbuzz_tx_sequencer.

## Test plan
- N_MAX=15, tx_ready=1 always, one start pulse → exact stream "1\r\n2\r\nFizz\r\n4\r\nBuzz\r\n…14\r\nFizzBuzz\r\n" (73 bytes); exactly one done pulse; count=0x0015 at end.
- N_MAX=15, tx_ready random at 30% → identical 73-byte stream; tx_data constant across every stalled cycle; tx_valid never drops while unaccepted.
- N_MAX=101 → last three lines "Fizz", "Buzz", "101"; first and last digits of the 3-digit value correct; no leading '0' on any line.
- abort asserted while 'z' of the first "Fizz" is pending with tx_ready=0 → 'z' still transfers when tx_ready rises; tx_valid=0 afterwards; busy=0; no done; a new start restarts from "1".
- start pulses during a run and start+abort together in IDLE → both ignored; the stream is unchanged.
- rst_n low mid-line → tx_valid, busy, done and count are 0 before the next edge; after release, start produces the stream from "1\r\n".

Source files
------------

// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the FizzBuzz UART transmit sequencer.
// Holds the FSM states, ASCII bytes, the word ROM and small elaboration helpers.
package fizzbuzz_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLASSIFY,
      S_EMIT_WORD,
      S_EMIT_DIGITS,
      S_EMIT_CR,
      S_EMIT_LF,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [7:0] ASCII_F  = 8'h46;
   localparam logic [7:0] ASCII_I  = 8'h69;
   localparam logic [7:0] ASCII_Z  = 8'h7A;
   localparam logic [7:0] ASCII_B  = 8'h42;
   localparam logic [7:0] ASCII_U  = 8'h75;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;

   // "FizzBuzz" is simply the Fizz range followed by the Buzz range
   localparam logic [2:0] FIZZ_FIRST = 3'd0;
   localparam logic [2:0] FIZZ_LAST  = 3'd3;
   localparam logic [2:0] BUZZ_FIRST = 3'd4;
   localparam logic [2:0] BUZZ_LAST  = 3'd7;

   function automatic logic [7:0] word_rom(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = ASCII_F;
         3'd1:    b = ASCII_I;
         3'd4:    b = ASCII_B;
         3'd5:    b = ASCII_U;
         default: b = ASCII_Z;
      endcase
      return b;
   endfunction

   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

   // Elaboration-time binary to packed BCD, used for the terminal value
   function automatic logic [63:0] to_bcd(input int unsigned n);
      logic [63:0] r;
      int unsigned v;
      r = '0;
      v = n;
      for (int i = 0; i < 16; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD incrementer with synchronous load-to-one.
// Also reports the most significant nonzero digit for zero suppression.
module bcd_counter
   import fizzbuzz_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int IW     = idx_width(DIGITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load1,
   input  logic                i_inc,
   output logic [4*DIGITS-1:0] o_count,
   output logic [IW-1:0]       o_msd
);

   localparam int CW = 4 * DIGITS;

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_next;
   logic          w_carry;

   // Ripple the carry from the least significant digit upward
   always_comb begin
      w_next  = r_count;
      w_carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (w_carry) begin
            if (r_count[4*d +: 4] == 4'd9) begin
               w_next[4*d +: 4] = 4'd0;
            end else begin
               w_next[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
               w_carry = 1'b0;
            end
         end
      end
   end

   // Highest nonzero digit wins; a zero count reports digit 0
   always_comb begin
      o_msd = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_count[4*d +: 4] != 4'd0) begin
            o_msd = IW'(d);
         end
      end
   end

   // Count register: load to one at run start, step on request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load1) begin
         r_count <= CW'(1);
      end else if (i_inc) begin
         r_count <= w_next;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fizzbuzz_tx_sequencer.sv
// Prints FizzBuzz 1..N_MAX over a valid/ready byte stream, CR LF per line.
// Classification uses mod-3/mod-5 counters; digits come from a BCD counter.
module fizzbuzz_tx_sequencer
   import fizzbuzz_pkg::*;
#(
   parameter int N_MAX  = 100,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] count
);

   localparam int              CW         = 4 * DIGITS;
   localparam int              IW         = idx_width(DIGITS);
   localparam logic [63:0]     NMAX_BCD64 = to_bcd(N_MAX);
   localparam logic [CW-1:0]   NMAX_BCD   = NMAX_BCD64[CW-1:0];

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_mod3;
   logic [2:0]    r_mod5;
   logic [2:0]    r_widx;
   logic [2:0]    r_wend;
   logic [IW-1:0] r_didx;
   logic [IW-1:0] w_msd;
   logic [3:0]    w_digit;
   logic          w_fire;
   logic          w_last;
   logic          w_load;
   logic          w_inc;
   logic          w_classify;
   logic          w_word_adv;
   logic          w_dig_adv;

   bcd_counter #(
      .DIGITS (DIGITS),
      .IW     (IW)
   ) u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load1 (w_load),
      .i_inc   (w_inc),
      .o_count (count),
      .o_msd   (w_msd)
   );

   assign w_fire  = tx_valid & tx_ready;
   assign w_last  = (count == NMAX_BCD);
   assign w_digit = count[4*r_didx +: 4];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, byte mux and datapath strobes; abort acts only at byte boundaries
   always_comb begin
      w_state_nxt = r_state;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      busy        = 1'b1;
      done        = 1'b0;
      w_load      = 1'b0;
      w_inc       = 1'b0;
      w_classify  = 1'b0;
      w_word_adv  = 1'b0;
      w_dig_adv   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start && !abort) begin
               w_state_nxt = S_CLASSIFY;
               w_load      = 1'b1;
            end
         end
         S_CLASSIFY: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_classify = 1'b1;
               if (r_mod3 == 2'd0 || r_mod5 == 3'd0) begin
                  w_state_nxt = S_EMIT_WORD;
               end else begin
                  w_state_nxt = S_EMIT_DIGITS;
               end
            end
         end
         S_EMIT_WORD: begin
            tx_valid = 1'b1;
            tx_data  = word_rom(r_widx);
            if (w_fire) begin
               w_word_adv = 1'b1;
               if (abort) begin
                  w_state_nxt = S_IDLE;
               end else if (r_widx == r_wend) begin
                  w_state_nxt = S_EMIT_CR;
               end
            end
         end
         S_EMIT_DIGITS: begin
            tx_valid = 1'b1;
            tx_data  = ASCII_0 | {4'h0, w_digit};
            if (w_fire) begin
               w_dig_adv = 1'b1;
               if (abort) begin
                  w_state_nxt = S_IDLE;
               end else if (r_didx == '0) begin
                  w_state_nxt = S_EMIT_CR;
               end
            end
         end
         S_EMIT_CR: begin
            tx_valid = 1'b1;
            tx_data  = ASCII_CR;
            if (w_fire) begin
               w_state_nxt = abort ? S_IDLE : S_EMIT_LF;
            end
         end
         S_EMIT_LF: begin
            tx_valid = 1'b1;
            tx_data  = ASCII_LF;
            if (w_fire) begin
               if (abort) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = w_last ? S_DONE : S_NEXT;
               end
            end
         end
         S_NEXT: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_inc       = 1'b1;
               w_state_nxt = S_CLASSIFY;
            end
         end
         S_DONE: begin
            busy        = 1'b0;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Mod counters, word range and digit pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mod3 <= 2'd0;
         r_mod5 <= 3'd0;
         r_widx <= 3'd0;
         r_wend <= 3'd0;
         r_didx <= '0;
      end else begin
         if (w_load) begin
            r_mod3 <= 2'd1;
            r_mod5 <= 3'd1;
         end else if (w_inc) begin
            r_mod3 <= (r_mod3 == 2'd2) ? 2'd0 : r_mod3 + 2'd1;
            r_mod5 <= (r_mod5 == 3'd4) ? 3'd0 : r_mod5 + 3'd1;
         end
         if (w_classify) begin
            r_didx <= w_msd;
            if (r_mod3 == 2'd0 && r_mod5 == 3'd0) begin
               r_widx <= FIZZ_FIRST;
               r_wend <= BUZZ_LAST;
            end else if (r_mod3 == 2'd0) begin
               r_widx <= FIZZ_FIRST;
               r_wend <= FIZZ_LAST;
            end else begin
               r_widx <= BUZZ_FIRST;
               r_wend <= BUZZ_LAST;
            end
         end
         if (w_word_adv) begin
            r_widx <= r_widx + 3'd1;
         end
         if (w_dig_adv) begin
            r_didx <= r_didx - IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fizzbuzz_tx_sequencer.sv
// Scoreboard bench: two sequencers (N_MAX 15 and 101) share stimulus;
// expected text comes from plain FizzBuzz arithmetic on integers.
module tb_fizzbuzz_tx_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        tx_ready = 1'b0;
   logic [7:0]  a_data, b_data;
   logic        a_valid, b_valid;
   logic        a_busy, b_busy;
   logic        a_done, b_done;
   logic [15:0] a_count, b_count;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   int nd_a = 0;
   int nd_b = 0;
   int exp_done = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   fizzbuzz_tx_sequencer #(.N_MAX(15), .DIGITS(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .tx_data(a_data), .tx_valid(a_valid), .tx_ready(tx_ready),
      .busy(a_busy), .done(a_done), .count(a_count)
   );

   fizzbuzz_tx_sequencer #(.N_MAX(101), .DIGITS(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .tx_data(b_data), .tx_valid(b_valid), .tx_ready(tx_ready),
      .busy(b_busy), .done(b_done), .count(b_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic string line_of(input int v);
      if (v % 15 == 0) return "FizzBuzz";
      if (v % 3 == 0) return "Fizz";
      if (v % 5 == 0) return "Buzz";
      return $sformatf("%0d", v);
   endfunction

   task automatic push_stream(input int id, input int nmax, input int limit);
      logic [7:0] s[$];
      string t;
      for (int v = 1; v <= nmax; v++) begin
         t = line_of(v);
         for (int c = 0; c < t.len(); c++) s.push_back(t[c]);
         s.push_back(8'h0D);
         s.push_back(8'h0A);
      end
      for (int k = 0; k < s.size(); k++) begin
         if (limit < 0 || k < limit) begin
            if (id == 0) q0.push_back(s[k]);
            else q1.push_back(s[k]);
         end
      end
   endtask

   // tx_ready driver: always high, random 30%, or left to the stimulus
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) tx_ready = 1'b1;
      else if (rdy_mode == 1) tx_ready = ($urandom_range(0, 99) < 30);
   end

   // Monitor: pops the scoreboard on every transfer, checks stalls and done
   bit         m_stall[2];
   bit         m_lf[2];
   bit         m_pdone[2];
   logic [7:0] m_hold[2];
   logic [7:0] m_d, m_e;
   logic       m_v, m_b, m_dn;
   int         m_sz;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_stall[i] = 0;
            m_lf[i] = 0;
            m_pdone[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_d  = (i == 0) ? a_data : b_data;
            m_v  = (i == 0) ? a_valid : b_valid;
            m_b  = (i == 0) ? a_busy : b_busy;
            m_dn = (i == 0) ? a_done : b_done;
            if (m_stall[i]) begin
               chk($sformatf("hold_valid%0d", i), 32'(m_v), 1);
               chk($sformatf("hold_data%0d", i), 32'(m_d), 32'(m_hold[i]));
            end
            if (m_dn) begin
               if (i == 0) nd_a++;
               else nd_b++;
               chk($sformatf("done_busy%0d", i), 32'(m_b), 0);
               chk($sformatf("done_after_lf%0d", i), 32'(m_lf[i]), 1);
               chk($sformatf("done_width%0d", i), 32'(m_pdone[i]), 0);
            end
            if (m_v && tx_ready) begin
               m_sz = (i == 0) ? q0.size() : q1.size();
               if (m_sz == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_byte%0d actual=%0h expected=none",
                           i, m_d);
               end else begin
                  m_e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("byte%0d", i), 32'(m_d), 32'(m_e));
               end
            end
            m_lf[i]    = m_v && tx_ready && (m_d == 8'h0A);
            m_stall[i] = m_v && !tx_ready;
            m_hold[i]  = m_d;
            m_pdone[i] = m_dn;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_runs(input bit jitter);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || a_busy || b_busy)
             && n < 20000) begin
         @(posedge clk); #1;
         start = jitter && a_busy && b_busy && ($urandom_range(0, 19) == 0);
         n++;
      end
      start = 1'b0;
      if (n >= 20000) begin
         checks++;
         errors++;
         $display("FAIL run_timeout actual=%0d expected<20000", n);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic end_checks(input logic [15:0] ea, input logic [15:0] eb);
      chk("count_a", 32'(a_count), 32'(ea));
      chk("count_b", 32'(b_count), 32'(eb));
      chk("done_cnt_a", nd_a, exp_done);
      chk("done_cnt_b", nd_b, exp_done);
      chk("busy_a", 32'(a_busy), 0);
      chk("busy_b", 32'(b_busy), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, {a_valid, b_valid}, 0);
      chk({tag, "_data"}, {a_data, b_data}, 0);
      chk({tag, "_busy"}, {a_busy, b_busy}, 0);
      chk({tag, "_done"}, {a_done, b_done}, 0);
      chk({tag, "_count"}, {a_count, b_count}, 0);
   endtask

   initial begin
      bit found;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Full run, ready always high, with start latency checks
      rdy_mode = 0;
      push_stream(0, 15, -1);
      push_stream(1, 101, -1);
      exp_done++;
      pulse_start();
      chk("lat_busy", {a_busy, b_busy}, 2'b11);
      chk("lat_classify", {a_valid, b_valid}, 0);
      @(posedge clk); #1;
      chk("lat_valid", {a_valid, b_valid}, 2'b11);
      chk("first_byte", 32'(a_data), 32'h31);
      wait_runs(1'b0);
      end_checks(16'h0015, 16'h0101);

      // Random 30% ready, with stray start pulses mid-run
      rdy_mode = 1;
      push_stream(0, 15, -1);
      push_stream(1, 101, -1);
      exp_done++;
      pulse_start();
      wait_runs(1'b1);
      end_checks(16'h0015, 16'h0101);

      // start and abort together in IDLE
      rdy_mode = 0;
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", {a_busy, b_busy}, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("sa_valid", {a_valid, b_valid}, 0);

      // Abort while the first 'z' of "Fizz" is stalled
      rdy_mode = 2;
      tx_ready = 1'b1;
      push_stream(0, 15, 9);
      push_stream(1, 101, 9);
      pulse_start();
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(posedge clk); #1;
         if (a_valid && a_data == 8'h7A) found = 1;
      end
      chk("abort_reach_z", 32'(found), 1);
      tx_ready = 1'b0;
      abort = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_hold_v", {a_valid, b_valid}, 2'b11);
      chk("abort_hold_d", {a_data, b_data}, 16'h7A7A);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      chk("abort_valid", {a_valid, b_valid}, 0);
      chk("abort_busy", {a_busy, b_busy}, 0);
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_drain", q0.size() + q1.size(), 0);
      end_checks(16'h0003, 16'h0003);

      rdy_mode = 0;
      push_stream(0, 15, -1);
      push_stream(1, 101, -1);
      exp_done++;
      pulse_start();
      wait_runs(1'b0);
      end_checks(16'h0015, 16'h0101);

      // Reset in the middle of a line
      rdy_mode = 1;
      push_stream(0, 15, -1);
      push_stream(1, 101, -1);
      pulse_start();
      repeat (20) @(posedge clk);
      #1;
      for (int k = 0; k < 50 && !a_valid; k++) begin
         @(posedge clk); #1;
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      q0.delete();
      q1.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      rdy_mode = 0;
      push_stream(0, 15, -1);
      push_stream(1, 101, -1);
      exp_done++;
      pulse_start();
      wait_runs(1'b0);
      end_checks(16'h0015, 16'h0101);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
